// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiters.
package fifo_arb_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_MAX_BURST = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  function automatic int ID_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping modulo N.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N = DEF_NUM_REQ
) (
  input  logic [N-1:0]       req,
  input  logic [ID_W(N)-1:0] rr_ptr,
  output logic               valid,
  output logic [ID_W(N)-1:0] idx
);

  localparam int IW = ID_W(N);

  logic [IW:0] cand_s;

  // scan offsets from the far end down so the nearest requester is the last one kept
  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    cand_s = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand_s = {1'b0, rr_ptr} + (IW + 1)'(k);
      if (cand_s >= (IW + 1)'(N)) begin
        cand_s = cand_s - (IW + 1)'(N);
      end else begin
        cand_s = cand_s;
      end
      if (req[cand_s[IW-1:0]]) begin
        valid = 1'b1;
        idx   = cand_s[IW-1:0];
      end else begin
        valid = valid;
        idx   = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter for the shared FIFO write port, with
// full/almostfull throttling and write-ack / overflow monitoring.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int FIFO_WIDTH = 16,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          fifo_full,
  input  logic                          fifo_almostfull,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  output logic [ID_W(NUM_REQ)-1:0]      owner,
  output logic                          ack_err,
  output logic                          ovf_err
);

  localparam int IW = ID_W(NUM_REQ);

  arb_state_t    state_r, state_nxt_s;
  logic [IW-1:0] rr_ptr_r, rr_ptr_nxt_s;
  logic [IW-1:0] lock_id_r, lock_id_nxt_s;
  logic [IW-1:0] grant_idx_s, pick_idx_s;
  logic [3:0]    beat_cnt_r, beat_cnt_nxt_s;
  logic          space_ok_s, pick_valid_s, grant_s, pend_r;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    return (v == IW'(NUM_REQ - 1)) ? '0 : v + IW'(1);
  endfunction

  // A write already in flight while almost full takes the last free slot.
  assign space_ok_s = !fifo_full && !(fifo_almostfull && fifo_wr_en);
  assign ack_err    = pend_r && !fifo_wr_ack;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_r),
    .valid  (pick_valid_s),
    .idx    (pick_idx_s)
  );

  // next state, grant decision and pointer/lock bookkeeping
  always_comb begin
    state_nxt_s    = state_r;
    rr_ptr_nxt_s   = rr_ptr_r;
    lock_id_nxt_s  = lock_id_r;
    beat_cnt_nxt_s = beat_cnt_r;
    grant_s        = 1'b0;
    grant_idx_s    = lock_id_r;
    if (!rst_n) begin
      grant_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (space_ok_s && pick_valid_s) begin
            grant_s        = 1'b1;
            grant_idx_s    = pick_idx_s;
            lock_id_nxt_s  = pick_idx_s;
            beat_cnt_nxt_s = 4'd1;
            if (MAX_BURST > 1) begin
              state_nxt_s = BURST;
            end else begin
              rr_ptr_nxt_s = wrap_inc(pick_idx_s);
            end
          end else begin
            grant_s = 1'b0;
          end
        end
        BURST: begin
          // exit cycle never grants, leaving one bubble between owners
          if (!req[lock_id_r] || (beat_cnt_r >= 4'(MAX_BURST))) begin
            state_nxt_s  = IDLE;
            rr_ptr_nxt_s = wrap_inc(lock_id_r);
          end else if (space_ok_s) begin
            grant_s        = 1'b1;
            beat_cnt_nxt_s = beat_cnt_r + 4'd1;
          end else begin
            grant_s = 1'b0;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // one-hot grant vector from the granted index
  always_comb begin
    gnt = '0;
    if (grant_s) begin
      gnt[grant_idx_s] = 1'b1;
    end else begin
      gnt = '0;
    end
  end

  // arbitration state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      rr_ptr_r   <= '0;
      lock_id_r  <= '0;
      beat_cnt_r <= 4'd0;
    end else begin
      state_r    <= state_nxt_s;
      rr_ptr_r   <= rr_ptr_nxt_s;
      lock_id_r  <= lock_id_nxt_s;
      beat_cnt_r <= beat_cnt_nxt_s;
    end
  end

  // registered FIFO write port; data and owner hold between writes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fifo_wr_en   <= 1'b0;
      fifo_data_in <= '0;
      owner        <= '0;
    end else begin
      fifo_wr_en <= grant_s;
      if (grant_s) begin
        fifo_data_in <= req_data[int'(grant_idx_s) * FIFO_WIDTH +: FIFO_WIDTH];
        owner        <= grant_idx_s;
      end
    end
  end

  // pending-ack tracker and sticky overflow flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_r  <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      pend_r  <= fifo_wr_en;
      ovf_err <= ovf_err | fifo_overflow;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: expected writes are queued when a grant
// is predicted and checked when the registered write appears.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int NR = 4;
  localparam int FW = 16;
  localparam int MB = 4;

  typedef struct packed {
    logic [1:0]    own;
    logic [FW-1:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req = '0;
  logic [NR*FW-1:0] req_data;
  logic [NR-1:0]   gnt;
  logic            fifo_full = 1'b0;
  logic            fifo_almostfull = 1'b0;
  logic            fifo_wr_ack = 1'b0;
  logic            fifo_overflow = 1'b0;
  logic            suppress_ack = 1'b0;
  logic            fifo_wr_en;
  logic [FW-1:0]   fifo_data_in;
  logic [1:0]      owner;
  logic            ack_err;
  logic            ovf_err;

  logic [FW-1:0] pdata [NR];
  exp_t sbq[$];
  int total = 0;
  int bad = 0;

  for (genvar g = 0; g < NR; g++) begin : g_data
    assign req_data[g*FW +: FW] = pdata[g];
  end

  fifo_wr_arbiter #(.NUM_REQ(NR), .FIFO_WIDTH(FW), .MAX_BURST(MB)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req             (req),
    .req_data        (req_data),
    .gnt             (gnt),
    .fifo_full       (fifo_full),
    .fifo_almostfull (fifo_almostfull),
    .fifo_wr_ack     (fifo_wr_ack),
    .fifo_overflow   (fifo_overflow),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_data_in    (fifo_data_in),
    .owner           (owner),
    .ack_err         (ack_err),
    .ovf_err         (ovf_err)
  );

  initial forever #5 clk = ~clk;

  // FIFO model: registered wr_ack, optionally suppressed for one write
  always @(posedge clk) fifo_wr_ack <= fifo_wr_en & ~suppress_ack;

  function automatic logic [1:0] oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic test_reset();
    req = 4'b1111;
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (gnt !== 4'b0000 || fifo_wr_en !== 1'b0 || owner !== 2'd0 || fifo_data_in !== 16'h0000 ||
          ack_err !== 1'b0 || ovf_err !== 1'b0 || dut.state_r !== IDLE) begin
        bad++;
        $display("FAIL reset c%0d: gnt=%b wr_en=%b owner=%0d data=%h ack_err=%b ovf_err=%b state=%0d, want all zero/IDLE",
                 c, gnt, fifo_wr_en, owner, fifo_data_in, ack_err, ovf_err, dut.state_r);
      end
      @(posedge clk); #1;
    end
    req = 4'b0000;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fairness();
    exp_t e;
    logic [3:0] eg, gs;
    for (int c = 0; c < 23; c++) begin
      req = (c <= 20) ? 4'b1111 : 4'b0000;
      eg  = (c <= 20 && (c % 5) < 4) ? (4'b0001 << ((c / 5) % 4)) : 4'b0000;
      @(negedge clk);
      total++;
      if (fifo_wr_en !== 1'b0) begin
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL fair_wr c%0d: unexpected write owner=%0d data=%h", c, owner, fifo_data_in);
        end else begin
          e = sbq.pop_front();
          if (owner !== e.own || fifo_data_in !== e.data) begin
            bad++;
            $display("FAIL fair_wr c%0d: got owner=%0d data=%h want owner=%0d data=%h", c, owner, fifo_data_in, e.own, e.data);
          end
        end
      end else if (sbq.size() != 0) begin
        e = sbq.pop_front();
        bad++;
        $display("FAIL fair_wr c%0d: missing write, want owner=%0d data=%h", c, e.own, e.data);
      end
      total++;
      if (gnt !== eg) begin
        bad++;
        $display("FAIL fair_gnt c%0d: got %b want %b", c, gnt, eg);
      end
      if (eg != 4'b0000) begin
        e.own = oh_idx(eg);
        e.data = pdata[oh_idx(eg)];
        sbq.push_back(e);
      end
      gs = gnt;
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) if (gs[i]) pdata[i] = pdata[i] + 16'd1;
    end
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL fair_drain: %0d writes outstanding, want 0", sbq.size());
    end
  endtask

  task automatic test_early_end();
    exp_t e;
    logic [3:0] eg, gs;
    for (int c = 0; c < 7; c++) begin
      req = (c < 2) ? 4'b0100 : (c == 4) ? 4'b1111 : 4'b0000;
      eg  = (c < 2) ? 4'b0100 : (c == 4) ? 4'b1000 : 4'b0000;
      @(negedge clk);
      total++;
      if (fifo_wr_en !== 1'b0) begin
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL early_wr c%0d: unexpected write owner=%0d data=%h", c, owner, fifo_data_in);
        end else begin
          e = sbq.pop_front();
          if (owner !== e.own || fifo_data_in !== e.data) begin
            bad++;
            $display("FAIL early_wr c%0d: got owner=%0d data=%h want owner=%0d data=%h", c, owner, fifo_data_in, e.own, e.data);
          end
        end
      end else if (sbq.size() != 0) begin
        e = sbq.pop_front();
        bad++;
        $display("FAIL early_wr c%0d: missing write, want owner=%0d data=%h", c, e.own, e.data);
      end
      total++;
      if (gnt !== eg) begin
        bad++;
        $display("FAIL early_gnt c%0d: got %b want %b", c, gnt, eg);
      end
      if (eg != 4'b0000) begin
        e.own = oh_idx(eg);
        e.data = pdata[oh_idx(eg)];
        sbq.push_back(e);
      end
      gs = gnt;
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) if (gs[i]) pdata[i] = pdata[i] + 16'd1;
    end
  endtask

  task automatic test_throttle();
    exp_t e;
    logic [3:0] eg, gs;
    for (int c = 0; c < 15; c++) begin
      req = (c < 4) ? 4'b0010 : (c <= 12) ? 4'b0011 : 4'b0000;
      fifo_almostfull = (c >= 1 && c <= 3);
      fifo_full       = (c >= 4 && c <= 8);
      eg = (c == 0 || c == 2 || c == 9 || c == 10) ? 4'b0010 : (c == 12) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      total++;
      if (fifo_wr_en !== 1'b0) begin
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL thr_wr c%0d: unexpected write owner=%0d data=%h", c, owner, fifo_data_in);
        end else begin
          e = sbq.pop_front();
          if (owner !== e.own || fifo_data_in !== e.data) begin
            bad++;
            $display("FAIL thr_wr c%0d: got owner=%0d data=%h want owner=%0d data=%h", c, owner, fifo_data_in, e.own, e.data);
          end
        end
      end else if (sbq.size() != 0) begin
        e = sbq.pop_front();
        bad++;
        $display("FAIL thr_wr c%0d: missing write, want owner=%0d data=%h", c, e.own, e.data);
      end
      total++;
      if (gnt !== eg) begin
        bad++;
        $display("FAIL thr_gnt c%0d: got %b want %b", c, gnt, eg);
      end
      if (c == 6) begin
        total++;
        if (dut.state_r !== BURST || dut.lock_id_r !== 2'd1) begin
          bad++;
          $display("FAIL thr_lock: state=%0d lock=%0d want BURST lock=1", dut.state_r, dut.lock_id_r);
        end
      end
      if (eg != 4'b0000) begin
        e.own = oh_idx(eg);
        e.data = pdata[oh_idx(eg)];
        sbq.push_back(e);
      end
      gs = gnt;
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) if (gs[i]) pdata[i] = pdata[i] + 16'd1;
    end
    fifo_almostfull = 1'b0;
    fifo_full = 1'b0;
  endtask

  task automatic test_ack_check();
    logic exp_err;
    for (int c = 0; c < 8; c++) begin
      req = (c < 4) ? 4'b0010 : 4'b0000;
      suppress_ack = (c == 3);
      exp_err = (c == 4);
      @(negedge clk);
      total++;
      if (ack_err !== exp_err) begin
        bad++;
        $display("FAIL ack_err c%0d: got %b want %b", c, ack_err, exp_err);
      end
      @(posedge clk); #1;
    end
    suppress_ack = 1'b0;
  endtask

  task automatic test_overflow();
    logic exp_ovf;
    for (int c = 0; c < 5; c++) begin
      fifo_overflow = (c == 0);
      exp_ovf = (c >= 1);
      @(negedge clk);
      total++;
      if (ovf_err !== exp_ovf) begin
        bad++;
        $display("FAIL ovf_err c%0d: got %b want %b", c, ovf_err, exp_ovf);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_burst();
    req = 4'b1111;
    @(negedge clk);
    total++;
    if (gnt !== 4'b0100) begin bad++; $display("FAIL mid_beat1: gnt=%b want 0100", gnt); end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (gnt !== 4'b0100 || fifo_wr_en !== 1'b1 || owner !== 2'd2) begin
      bad++;
      $display("FAIL mid_beat2: gnt=%b wr_en=%b owner=%0d want 0100/1/2", gnt, fifo_wr_en, owner);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (gnt !== 4'b0000 || fifo_wr_en !== 1'b1 || ovf_err !== 1'b1) begin
      bad++;
      $display("FAIL mid_rst_in: gnt=%b wr_en=%b ovf_err=%b want 0000/1/1", gnt, fifo_wr_en, ovf_err);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (gnt !== 4'b0000 || fifo_wr_en !== 1'b0 || owner !== 2'd0 || fifo_data_in !== 16'h0000 ||
        ovf_err !== 1'b0 || ack_err !== 1'b0) begin
      bad++;
      $display("FAIL mid_rst_out: gnt=%b wr_en=%b owner=%0d data=%h ovf=%b ack=%b want all zero",
               gnt, fifo_wr_en, owner, fifo_data_in, ovf_err, ack_err);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (gnt !== 4'b0001) begin bad++; $display("FAIL mid_restart: gnt=%b want 0001", gnt); end
    @(posedge clk); #1;
    req = 4'b0000;
    @(negedge clk);
    total++;
    if (fifo_wr_en !== 1'b1 || owner !== 2'd0 || gnt !== 4'b0000) begin
      bad++;
      $display("FAIL mid_restart_wr: wr_en=%b owner=%0d gnt=%b want 1/0/0000", fifo_wr_en, owner, gnt);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) pdata[i] = 16'(i * 4096 + 160);
    @(posedge clk); #1;
    test_reset();
    test_fairness();
    test_early_end();
    test_throttle();
    test_ack_check();
    test_overflow();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares the single write port of the team's synchronous FIFO between `NUM_REQ` producers. It grants one producer per cycle, with optional burst locking, and registers the selected word onto the FIFO `wr_en`/`data_in` inputs. It throttles on the FIFO `full`/`almostfull` flags so the FIFO never sees an overflowing write. It also checks that every issued write is answered by the FIFO's `wr_ack`.

## Interface
- `NUM_REQ`, 4: number of producers, 2..8.
- `FIFO_WIDTH`, 16: data word width; must equal the FIFO's width.
- `MAX_BURST`, 4: maximum consecutive beats one producer may hold the port, 1..15.
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `req` in `NUM_REQ`: per-producer write request; the producer holds it with its data stable until granted.
- `req_data` in `NUM_REQ*FIFO_WIDTH`: producer i owns slice `[i*FIFO_WIDTH +: FIFO_WIDTH]`.
- `gnt` out `NUM_REQ`: one-hot or zero, combinational; high means the beat is accepted this cycle.
- `fifo_full` in 1: FIFO `full`.
- `fifo_almostfull` in 1: FIFO `almostfull`.
- `fifo_wr_ack` in 1: FIFO `wr_ack` (registered in the FIFO).
- `fifo_overflow` in 1: FIFO `overflow`.
- `fifo_wr_en` out 1: registered write enable to the FIFO.
- `fifo_data_in` out `FIFO_WIDTH`: registered write data.
- `owner` out `$clog2(NUM_REQ)`: registered index of the producer behind the current `fifo_wr_en`.
- `ack_err` out 1: one-cycle pulse when an issued write gets no `fifo_wr_ack`.
- `ovf_err` out 1: sticky; set when `fifo_overflow` is seen. Cleared only by reset.

## Operation
- **Space check.**
  - `space_ok = !fifo_full && !(fifo_almostfull && fifo_wr_en)`.
  - A write already in flight while the FIFO is almost full consumes the last slot.
  - Reads are ignored, so the check is conservative.
- **State machine.** States are `IDLE` and `BURST`.
  - **`IDLE`:**
    - If `space_ok` and any `req` is high, pick the first requester at or after `rr_ptr`, cycling modulo `NUM_REQ`.
    - Assert its `gnt`, load `lock_id`, set `beat_cnt=1`.
    - If `MAX_BURST>1`, go to `BURST`.
    - `rr_ptr` becomes `lock_id+1` (mod `NUM_REQ`) when the burst ends.
  - **`BURST`:**
    - Grant is allowed only to `lock_id`.
    - If `req[lock_id]` and `space_ok` are both high, grant and increment `beat_cnt`.
    - If `req[lock_id]` is high and `space_ok` is low, stall in `BURST` with no grant; the lock is kept.
    - Exit to `IDLE` and advance `rr_ptr` when `req[lock_id]` drops, or on the beat where `beat_cnt` reaches `MAX_BURST`.
    - The `IDLE` pick does not happen in the exit cycle, so there is one bubble cycle between owners.
- **Registered outputs.**
  - On the edge after a grant, `fifo_wr_en<=1`, `fifo_data_in<=` the granted slice, and `owner<=` the granted index.
  - Otherwise `fifo_wr_en<=0`; `fifo_data_in` and `owner` hold their values.
- **Ack check.** `pend_q<=fifo_wr_en`. In any cycle with `pend_q=1` and `fifo_wr_ack=0`, pulse `ack_err`.
- **Reset value of every output.** `fifo_wr_en=0`, `fifo_data_in=0`, `owner=0`, `ack_err=0`, `ovf_err=0`, `gnt=0`.
- **Reset value of internal state.** State `IDLE`, `rr_ptr=0`, `beat_cnt=0`, `pend_q=0`.
- **Reset mid-burst.** The lock is abandoned. Any in-flight `fifo_wr_en` is dropped on the reset edge.

## Timing
- Data takes one cycle from grant to `fifo_wr_en`. The FIFO acks one cycle later, so `gnt` to `fifo_wr_ack` is 2 cycles.
- Sustained throughput is 1 beat/cycle within a burst.
- Between owners, the steady state is `MAX_BURST` beats followed by 1 idle cycle.
- `gnt` depends combinationally on `req`, flags, state and `rr_ptr`. The FIFO outputs do not depend combinationally on `req`.
- `beat_cnt` is 4 bits. `rr_ptr` and `lock_id` wrap modulo `NUM_REQ`, which need not be a power of two.

## Structure
- Shared package `fifo_arb_pkg`:
  - `arb_state_t` enum (`IDLE`, `BURST`).
  - `ID_W` function (`$clog2`).
  - Defaults for `NUM_REQ` and `MAX_BURST`.
- One sub-module, `rr_pick`: combinational round-robin picker with inputs `req` and `rr_ptr`, outputs `valid` and `idx`. It is reused by other arbiters.
- The top module holds the FSM, the output registers and the ack/overflow checker.

## Test plan
- **Reset.** Hold `rst_n=0` for 2 cycles with all `req` high → `gnt=0`, `fifo_wr_en=0`, `owner=0`, state `IDLE`.
- **Fairness.** `NUM_REQ=4`, `MAX_BURST=4`, all `req` held high, FIFO never full → exactly 4 beats per producer. Order is 0,1,2,3,0, with 1 bubble between owners.
- **Early burst end.** `req[2]` alone, dropped after 2 beats → 2 `fifo_wr_en` pulses carrying producer 2's data. Next grant starts at producer 3.
- **Throttling.**
  - With `fifo_almostfull=1` and a write in flight, the next grant is withheld.
  - With `fifo_full=1` for 5 cycles, there is no `fifo_wr_en` and the lock is kept.
  - After `fifo_full` drops, the stalled burst resumes with the same owner.
- **Ack/overflow checking.**
  - Suppress `fifo_wr_ack` on the third write → `ack_err` pulses exactly once, 2 cycles after that beat's `gnt`.
  - Force `fifo_overflow=1` → `ovf_err` sets and holds until reset.
- **Reset mid-burst.** Assert `rst_n=0` on beat 2 of a burst → all outputs return to reset values. Arbitration restarts from producer 0.
